// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle RV32I core. It sequences fetch/decode/execute/memory/writeback,
// owns the shared-memory req/ready handshake, and enters a sticky FAULT on illegal opcodes or memory timeout.
module multicycle_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       ir_we,
    output logic       pc_we,
    output logic       pc_src,
    output logic       tgt_we,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] aluop,
    output logic       reg_we,
    output logic       mem_to_reg,
    output logic       illegal,
    output logic       fault,
    output logic [3:0] state
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_EXEC_I = 4'd4,
        S_WB_ALU = 4'd5,
        S_ADDR   = 4'd6,
        S_MEM    = 4'd7,
        S_WB_MEM = 4'd8,
        S_BRANCH = 4'd9,
        S_FAULT  = 4'd10
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic             timed_out;
    logic             is_store;

    assign timed_out = (wait_q == TIMEOUT_VAL);
    assign is_store  = (opcode == OP_STORE);
    assign state     = state_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_RST;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 1'b0;
        tgt_we     = 1'b0;
        alu_src_a  = 2'd0;
        alu_src_b  = 2'd0;
        aluop      = 2'b00;
        reg_we     = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;
        fault      = 1'b0;

        case (state_q)
            S_RST: state_d = S_FETCH;

            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_a = 2'd0;
                alu_src_b = 2'd1;
                // PC+4 is written in the same cycle the instruction word arrives
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (timed_out) begin
                    state_d = S_FAULT;
                end
            end

            S_DECODE: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd2;
                tgt_we    = 1'b1;
                case (opcode)
                    OP_R:              state_d = S_EXEC_R;
                    OP_I:              state_d = S_EXEC_I;
                    OP_LOAD, OP_STORE: state_d = S_ADDR;
                    OP_BRANCH:         state_d = S_BRANCH;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FAULT;
                    end
                endcase
            end

            S_EXEC_R: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd0;
                aluop     = 2'b10;
                state_d   = S_WB_ALU;
            end

            S_EXEC_I: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd2;
                state_d   = S_WB_ALU;
            end

            S_WB_ALU: begin
                reg_we  = 1'b1;
                state_d = S_FETCH;
            end

            S_ADDR: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd2;
                state_d   = S_MEM;
            end

            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = is_store;
                if (mem_ready) begin
                    state_d = is_store ? S_FETCH : S_WB_MEM;
                end else if (timed_out) begin
                    state_d = S_FAULT;
                end
            end

            S_WB_MEM: begin
                reg_we     = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end

            S_BRANCH: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd0;
                aluop     = 2'b01;
                pc_src    = 1'b1;
                // funct3[0] distinguishes bne from beq, so it inverts the zero flag
                if (funct3[2:1] == 2'b00) begin
                    pc_we   = zero ^ funct3[0];
                    state_d = S_FETCH;
                end else begin
                    illegal = 1'b1;
                    state_d = S_FAULT;
                end
            end

            S_FAULT: fault = 1'b1;

            default: state_d = S_FAULT;
        endcase
    end

    // Wait counter restarts on every state change and saturates at the timeout value
    always_comb begin
        wait_d = wait_q;
        if (state_d != state_q) begin
            wait_d = '0;
        end else if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready && !timed_out) begin
            wait_d = wait_q + CNT_W'(1);
        end
    end

endmodule
